// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Program-counter sequencer sitting in front of a combinational instruction
//   memory. It drives the memory byte address from the pc register and registers
//   each returned word into a one-entry output slot. Decode reads the slot over a
//   valid/ready handshake. Branch redirects from execute replace the pc, and
//   fetching stops once pc runs past the end of the loaded program.
//
// Ports
//   clk, rst_n     clock and asynchronous active-low reset
//   start          1-cycle pulse, honoured in IDLE or DONE
//   imem_addr      byte address to instruction memory (the pc register)
//   imem_data      instruction word at imem_addr (combinational return)
//   instr          registered instruction word in the output slot
//   instr_pc       byte address of instr
//   instr_valid    output slot holds an instruction
//   instr_ready    decode accepts instr this cycle
//   branch_taken   redirect request (looked at in RUN/DRAIN only)
//   branch_target  redirect byte address, low two bits ignored
//   halted         program finished (state DONE)
//   fetch_count    completed transfers, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int unsigned NUM_INSTR = 13,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_data,
    output logic [31:0]      instr,
    output logic [31:0]      instr_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [31:0] END_ADDR = 32'(NUM_INSTR * 4);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fetchState_e;

    fetchState_e state;

    logic [31:0] alignedTarget;
    logic        targetInRange;
    logic        pcAtEnd;
    logic        slotFree;
    logic        transfer;

    // Decode helpers shared by the RUN and DRAIN branches of the sequencer.
    always_comb begin
        alignedTarget = {branch_target[31:2], 2'b00};
        targetInRange = (alignedTarget < END_ADDR);
        pcAtEnd       = (imem_addr >= END_ADDR);
        slotFree      = !instr_valid || instr_ready;
        // A redirect kills the held word, so it never counts as a transfer.
        transfer      = instr_valid && instr_ready && !branch_taken &&
                        ((state == RUN) || (state == DRAIN));
    end

    // Sequencer state, pc and the registered output slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            imem_addr   <= RESET_PC;
            instr       <= 32'h0000_0000;
            instr_pc    <= 32'h0000_0000;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= {CNT_W{1'b0}};
        end else begin
            if (transfer) begin
                fetch_count <= fetch_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        imem_addr <= RESET_PC;
                    end
                end

                RUN: begin
                    if (branch_taken) begin
                        instr_valid <= 1'b0;
                        imem_addr   <= alignedTarget;
                        if (!targetInRange) begin
                            state <= DRAIN;
                        end
                    end else if (pcAtEnd) begin
                        // Nothing left to capture; a word taken this cycle
                        // must not be presented a second time.
                        if (instr_ready) begin
                            instr_valid <= 1'b0;
                        end
                        state <= DRAIN;
                    end else if (slotFree) begin
                        instr       <= imem_data;
                        instr_pc    <= imem_addr;
                        instr_valid <= 1'b1;
                        imem_addr   <= imem_addr + 32'd4;
                    end
                    // Stall: pc and the slot hold their values.
                end

                DRAIN: begin
                    if (branch_taken) begin
                        instr_valid <= 1'b0;
                        if (targetInRange) begin
                            imem_addr <= alignedTarget;
                            state     <= RUN;
                        end else begin
                            state  <= DONE;
                            halted <= 1'b1;
                        end
                    end else if (slotFree) begin
                        instr_valid <= 1'b0;
                        state       <= DONE;
                        halted      <= 1'b1;
                    end
                end

                DONE: begin
                    if (start) begin
                        state       <= RUN;
                        imem_addr   <= RESET_PC;
                        halted      <= 1'b0;
                        fetch_count <= {CNT_W{1'b0}};
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//   Directed bench for fetch_sequencer. The instruction memory holds word i at
//   byte address 4*i for the 13-word program. Inputs change and outputs are
//   sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        halted;
    logic [15:0] fetch_count;

    int checks;
    int errors;

    fetch_sequencer #(
        .NUM_INSTR (13),
        .RESET_PC  (32'h0000_0000),
        .CNT_W     (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    // Instruction memory: word i = i, poison value past the program end.
    assign imem_data = (imem_addr < 32'd52) ? (imem_addr >> 2) : 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        start         = 1'b0;
        instr_ready   = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0000_0000;

        // Reset state
        #3;
        checkVal("rst_valid", 32'(instr_valid), 32'd0);
        checkVal("rst_halted", 32'(halted), 32'd0);
        checkVal("rst_count", 32'(fetch_count), 32'd0);
        checkVal("rst_addr", imem_addr, 32'h0);
        checkVal("rst_instr", instr, 32'h0);
        checkVal("rst_ipc", instr_pc, 32'h0);
        nextCycle();
        rst_n = 1'b1;
        nextCycle();
        nextCycle();
        checkVal("idle_valid", 32'(instr_valid), 32'd0);

        // T1: full program at full throughput
        start       = 1'b1;
        instr_ready = 1'b1;
        nextCycle();
        start = 1'b0;
        checkVal("t1_latency", 32'(instr_valid), 32'd0);
        for (int k = 0; k < 13; k++) begin
            nextCycle();
            checkVal("t1_valid", 32'(instr_valid), 32'd1);
            checkVal("t1_ipc", instr_pc, 32'(4 * k));
            checkVal("t1_instr", instr, 32'(k));
        end
        nextCycle();
        checkVal("t1_end_valid", 32'(instr_valid), 32'd0);
        checkVal("t1_count", 32'(fetch_count), 32'd13);
        nextCycle();
        checkVal("t1_halted", 32'(halted), 32'd1);
        checkVal("t1_valid_done", 32'(instr_valid), 32'd0);

        // T6: restart from DONE, then T2: stall on instr_pc=0x08
        start = 1'b1;
        nextCycle();
        start = 1'b0;
        checkVal("t6_halted", 32'(halted), 32'd0);
        checkVal("t6_count", 32'(fetch_count), 32'd0);
        nextCycle();
        checkVal("t6_valid", 32'(instr_valid), 32'd1);
        checkVal("t6_ipc", instr_pc, 32'h00);
        nextCycle();
        checkVal("t2_ipc4", instr_pc, 32'h04);
        nextCycle();
        checkVal("t2_ipc8", instr_pc, 32'h08);
        instr_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            nextCycle();
            checkVal("t2_stall_valid", 32'(instr_valid), 32'd1);
            checkVal("t2_stall_ipc", instr_pc, 32'h08);
            checkVal("t2_stall_instr", instr, 32'd2);
            checkVal("t2_stall_addr", imem_addr, 32'h0C);
            checkVal("t2_stall_count", 32'(fetch_count), 32'd2);
        end
        instr_ready = 1'b1;
        nextCycle();
        checkVal("t2_rel_ipc", instr_pc, 32'h0C);
        checkVal("t2_rel_instr", instr, 32'd3);
        checkVal("t2_rel_count", 32'(fetch_count), 32'd3);

        // T5: asynchronous reset between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("t5_valid", 32'(instr_valid), 32'd0);
        checkVal("t5_addr", imem_addr, 32'h0);
        checkVal("t5_instr", instr, 32'h0);
        checkVal("t5_ipc", instr_pc, 32'h0);
        checkVal("t5_count", 32'(fetch_count), 32'd0);
        checkVal("t5_halted", 32'(halted), 32'd0);
        nextCycle();
        rst_n = 1'b1;
        for (int s = 0; s < 3; s++) begin
            nextCycle();
            checkVal("t5_idle_valid", 32'(instr_valid), 32'd0);
            checkVal("t5_idle_addr", imem_addr, 32'h0);
        end

        // T3: redirect to 0x23 while instr_pc=0x08 is held
        start = 1'b1;
        nextCycle();
        start = 1'b0;
        nextCycle();
        checkVal("t3_ipc0", instr_pc, 32'h00);
        nextCycle();
        checkVal("t3_ipc4", instr_pc, 32'h04);
        nextCycle();
        checkVal("t3_ipc8", instr_pc, 32'h08);
        instr_ready = 1'b0;
        nextCycle();
        checkVal("t3_hold_ipc", instr_pc, 32'h08);
        instr_ready   = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0023;
        nextCycle();
        branch_taken = 1'b0;
        checkVal("t3_flush_valid", 32'(instr_valid), 32'd0);
        checkVal("t3_flush_addr", imem_addr, 32'h20);
        checkVal("t3_flush_count", 32'(fetch_count), 32'd2);
        nextCycle();
        checkVal("t3_tgt_valid", 32'(instr_valid), 32'd1);
        checkVal("t3_tgt_ipc", instr_pc, 32'h20);
        checkVal("t3_tgt_instr", instr, 32'd8);
        nextCycle();
        checkVal("t3_next_ipc", instr_pc, 32'h24);
        checkVal("t3_next_count", 32'(fetch_count), 32'd3);

        // T4: redirect past the program end
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0100;
        nextCycle();
        branch_taken = 1'b0;
        checkVal("t4_valid", 32'(instr_valid), 32'd0);
        checkVal("t4_addr", imem_addr, 32'h100);
        checkVal("t4_count", 32'(fetch_count), 32'd3);
        nextCycle();
        checkVal("t4_halted", 32'(halted), 32'd1);
        for (int s = 0; s < 3; s++) begin
            nextCycle();
            checkVal("t4_quiet_valid", 32'(instr_valid), 32'd0);
            checkVal("t4_quiet_halted", 32'(halted), 32'd1);
            checkVal("t4_quiet_count", 32'(fetch_count), 32'd3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
